smem_store_buffer: RTL and testbench

- Storage unit directly downstream of the backward-extension control stage (stage 1).
- Absorbs that stage's two write streams into two register-file banks:
  - curr bank: candidate intervals, `curr_x_*` stream.
  - mem bank: finished SMEMs, `mem_x_*` stream.
- Serves registered reads of the curr bank back to the backward loop.
- When stage 1 flags the last token of a read, drains the mem bank in address order over a valid/ready output toward the SMEM writer.

---
 rtl/smem_store_buffer.sv | 176 +++++++++++++++++
 tb/tb_smem_store_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/smem_store_buffer.sv
// rtl/smem_store_buffer.sv - curr/mem register-file banks with ordered SMEM drain
module smem_store_buffer #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int RN_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              store_valid_curr,
  input  logic [63:0]       curr_x_0,
  input  logic [63:0]       curr_x_1,
  input  logic [63:0]       curr_x_2,
  input  logic [63:0]       curr_x_info,
  input  logic [ADDR_W-1:0] curr_x_addr,
  input  logic              store_valid_mem,
  input  logic [63:0]       mem_x_0,
  input  logic [63:0]       mem_x_1,
  input  logic [63:0]       mem_x_2,
  input  logic [63:0]       mem_x_info,
  input  logic [ADDR_W-1:0] mem_x_addr,
  input  logic              last_one_read,
  input  logic [RN_W-1:0]   read_num,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [63:0]       rd_x_0,
  output logic [63:0]       rd_x_1,
  output logic [63:0]       rd_x_2,
  output logic [63:0]       rd_x_info,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_x_0,
  output logic [63:0]       out_x_1,
  output logic [63:0]       out_x_2,
  output logic [63:0]       out_x_info,
  output logic [RN_W-1:0]   out_read_num,
  output logic              out_last,
  output logic              out_done,
  output logic              busy,
  output logic              overflow_err
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  // Entries are packed {info, x_2, x_1, x_0}, x_0 in the low word.
  logic [255:0] curr_bank [DEPTH];
  logic [255:0] mem_bank  [DEPTH];

  state_t            state_q;
  logic [CNT_W-1:0]  mem_cnt_q;
  logic [CNT_W-1:0]  mem_cnt_d;
  logic [CNT_W-1:0]  ptr_q;
  logic [255:0]      rd_q;
  logic [255:0]      out_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              out_done_q;
  logic [RN_W-1:0]   out_read_num_q;
  logic              overflow_q;

  logic [255:0]      curr_wdata;
  logic [255:0]      mem_wdata;
  logic [255:0]      drain_head;
  logic [CNT_W-1:0]  mem_wr_cnt;
  logic              curr_we;
  logic              mem_try;
  logic              mem_we;

  assign curr_wdata = {curr_x_info, curr_x_2, curr_x_1, curr_x_0};
  assign mem_wdata  = {mem_x_info, mem_x_2, mem_x_1, mem_x_0};
  assign curr_we    = store_valid_curr && !stall;
  assign mem_try    = store_valid_mem && !stall;
  assign mem_we     = mem_try && (state_q == IDLE);
  assign mem_wr_cnt = {1'b0, mem_x_addr} + CNT_W'(1);

  // Count including a mem write accepted in this same cycle (no wrap at DEPTH).
  always_comb begin
    mem_cnt_d = mem_cnt_q;
    if (mem_we && (mem_wr_cnt > mem_cnt_q)) mem_cnt_d = mem_wr_cnt;
  end

  // Entry 0 can be written in the same cycle the drain starts; forward it.
  assign drain_head = (mem_we && (mem_x_addr == '0)) ? mem_wdata : mem_bank[0];

  // Bank storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (curr_we) curr_bank[curr_x_addr] <= curr_wdata;
    if (mem_we)  mem_bank[mem_x_addr]   <= mem_wdata;
  end

  // Registered curr read with write-first bypass; holds when stalled or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_en && !stall) begin
      if (curr_we && (curr_x_addr == rd_addr)) rd_q <= curr_wdata;
      else                                     rd_q <= curr_bank[rd_addr];
    end
  end

  // Drain FSM: counts mem writes in IDLE, streams entries 0..mem_cnt-1, pulses done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mem_cnt_q      <= '0;
      ptr_q          <= '0;
      out_q          <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      out_done_q     <= 1'b0;
      out_read_num_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      if (mem_try && (state_q != IDLE)) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          mem_cnt_q <= mem_cnt_d;
          if (last_one_read && !stall) begin
            out_read_num_q <= read_num;
            if (mem_cnt_d != '0) begin
              state_q     <= DRAIN;
              out_q       <= drain_head;
              out_valid_q <= 1'b1;
              out_last_q  <= (mem_cnt_d == CNT_W'(1));
              ptr_q       <= CNT_W'(1);
            end else begin
              state_q    <= DONE;
              out_done_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= DONE;
              out_done_q  <= 1'b1;
            end else begin
              out_q      <= mem_bank[ptr_q[ADDR_W-1:0]];
              ptr_q      <= ptr_q + CNT_W'(1);
              out_last_q <= (ptr_q == mem_cnt_q - CNT_W'(1));
            end
          end
        end
        DONE: begin
          out_done_q <= 1'b0;
          mem_cnt_q  <= '0;
          ptr_q      <= '0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign rd_x_0       = rd_q[63:0];
  assign rd_x_1       = rd_q[127:64];
  assign rd_x_2       = rd_q[191:128];
  assign rd_x_info    = rd_q[255:192];
  assign out_x_0      = out_q[63:0];
  assign out_x_1      = out_q[127:64];
  assign out_x_2      = out_q[191:128];
  assign out_x_info   = out_q[255:192];
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_done     = out_done_q;
  assign out_read_num = out_read_num_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_smem_store_buffer.sv
// tb/tb_smem_store_buffer.sv - randomized self-checking bench for smem_store_buffer
module tb_smem_store_buffer;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        store_valid_curr, store_valid_mem;
  logic [63:0] curr_x_0, curr_x_1, curr_x_2, curr_x_info;
  logic [63:0] mem_x_0, mem_x_1, mem_x_2, mem_x_info;
  logic [6:0]  curr_x_addr, mem_x_addr, rd_addr;
  logic        last_one_read, rd_en, out_ready;
  logic [9:0]  read_num, out_read_num;
  logic [63:0] rd_x_0, rd_x_1, rd_x_2, rd_x_info;
  logic [63:0] out_x_0, out_x_1, out_x_2, out_x_info;
  logic        out_valid, out_last, out_done, busy, overflow_err;

  always #5 clk = ~clk;

  smem_store_buffer #(.ADDR_W(7), .DEPTH(128), .RN_W(10)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .store_valid_curr(store_valid_curr), .curr_x_0(curr_x_0), .curr_x_1(curr_x_1),
    .curr_x_2(curr_x_2), .curr_x_info(curr_x_info), .curr_x_addr(curr_x_addr),
    .store_valid_mem(store_valid_mem), .mem_x_0(mem_x_0), .mem_x_1(mem_x_1),
    .mem_x_2(mem_x_2), .mem_x_info(mem_x_info), .mem_x_addr(mem_x_addr),
    .last_one_read(last_one_read), .read_num(read_num),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_x_0(rd_x_0), .rd_x_1(rd_x_1), .rd_x_2(rd_x_2), .rd_x_info(rd_x_info),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x_0(out_x_0), .out_x_1(out_x_1), .out_x_2(out_x_2), .out_x_info(out_x_info),
    .out_read_num(out_read_num), .out_last(out_last), .out_done(out_done),
    .busy(busy), .overflow_err(overflow_err)
  );

  // Reference model: plain arrays of entries {info,x2,x1,x0}
  logic [255:0] m_curr [128];
  logic [255:0] m_mem  [128];
  logic [255:0] m_rd;
  int           m_cnt;
  bit           m_ovf;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; store_valid_curr = 0; store_valid_mem = 0;
    last_one_read = 0; rd_en = 0; out_ready = 0; read_num = '0;
  endtask

  task automatic drive_mem(input logic [6:0] a, input logic [255:0] d);
    mem_x_addr = a;
    {mem_x_info, mem_x_2, mem_x_1, mem_x_0} = d;
  endtask

  // Curr-bank cycle: model computes read result from the bank rules, then compare
  task automatic curr_cycle(input bit wv, input logic [6:0] wa, input bit re,
                            input logic [6:0] ra, input bit st);
    logic [255:0] wd;
    wd = {r64(), r64(), r64(), r64()};
    stall = st; store_valid_curr = wv; curr_x_addr = wa; rd_en = re; rd_addr = ra;
    {curr_x_info, curr_x_2, curr_x_1, curr_x_0} = wd;
    if (re && !st) m_rd = (wv && wa == ra) ? wd : m_curr[ra];
    if (wv && !st) m_curr[wa] = wd;
    tick();
    store_valid_curr = 0; rd_en = 0; stall = 0;
    check("rd_x_0", rd_x_0, m_rd[63:0]);
    check("rd_x_info", rd_x_info, m_rd[255:192]);
  endtask

  // Fill mem addresses 0..n-1 (random stalls), optionally writing addr n with
  // last_one_read, then drain with random readiness. abort_after>=0 returns
  // after that many accepted beats without finishing.
  task automatic run_drain(input int n, input int rdy_pct, input bit same_wr,
                           input bit inject, input logic [9:0] rn, input int abort_after);
    logic [255:0] exp_q[$];
    logic [255:0] d;
    int i, acc, cyc;
    bit done_seen;
    i = 0;
    while (i < n) begin
      d = {r64(), r64(), r64(), r64()};
      stall = ($urandom_range(0, 3) == 0);
      store_valid_mem = 1;
      drive_mem(7'(i), d);
      if (!stall) begin
        m_mem[i] = d;
        if (i + 1 > m_cnt) m_cnt = i + 1;
        i++;
      end
      tick();
    end
    stall = 0; store_valid_mem = 0;
    last_one_read = 1; read_num = rn;
    if (same_wr) begin
      d = {r64(), r64(), r64(), r64()};
      store_valid_mem = 1;
      drive_mem(7'(n), d);
      m_mem[n] = d;
      if (n + 1 > m_cnt) m_cnt = n + 1;
    end
    for (int k = 0; k < m_cnt; k++) exp_q.push_back(m_mem[k]);
    tick();
    last_one_read = 0; store_valid_mem = 0; read_num = '0;
    check("busy_start", 64'(busy), 64'd1);
    acc = 0; done_seen = 0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (out_done) begin
        done_seen = 1;
        check("done_no_valid", 64'(out_valid), 64'd0);
        store_valid_mem = 0; last_one_read = 0; stall = 0; out_ready = 0;
        break;
      end
      if (acc == abort_after) return;
      out_ready = ($urandom_range(1, 100) <= rdy_pct);
      stall = $urandom_range(0, 1);
      last_one_read = ($urandom_range(0, 7) == 0);
      store_valid_mem = inject && ($urandom_range(0, 9) == 0);
      drive_mem(7'($urandom), {r64(), r64(), r64(), r64()});
      if (store_valid_mem && !stall) m_ovf = 1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(out_valid), 64'd0);
        end else begin
          check("out_x_0", out_x_0, exp_q[0][63:0]);
          check("out_x_info", out_x_info, exp_q[0][255:192]);
          check("out_last", 64'(out_last), 64'(exp_q.size() == 1));
          check("out_read_num", 64'(out_read_num), 64'(rn));
          if (out_ready) begin
            void'(exp_q.pop_front());
            acc++;
          end
        end
      end
      tick();
    end
    check("done_seen", 64'(done_seen), 64'd1);
    check("beats_left", 64'(exp_q.size()), 64'd0);
    check("accepted", 64'(acc), 64'(m_cnt));
    m_cnt = 0;
    tick();
    check("busy_after", 64'(busy), 64'd0);
    check("done_pulse_1cyc", 64'(out_done), 64'd0);
    check("overflow_err", 64'(overflow_err), 64'(m_ovf));
  endtask

  initial begin
    idle_inputs();
    curr_x_0 = '0; curr_x_1 = '0; curr_x_2 = '0; curr_x_info = '0; curr_x_addr = '0;
    mem_x_0 = '0; mem_x_1 = '0; mem_x_2 = '0; mem_x_info = '0; mem_x_addr = '0;
    rd_addr = '0;
    m_rd = '0; m_cnt = 0; m_ovf = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow_err), 64'd0);
    check("rst_done", 64'(out_done), 64'd0);
    check("rst_rd_x_0", rd_x_0, 64'd0);
    check("rst_out_x_info", out_x_info, 64'd0);

    // Populate both banks so every address holds a known value
    for (int a = 0; a < 128; a++) curr_cycle(1, 7'(a), 0, 7'd0, 0);
    for (int a = 0; a < 128; a++) begin
      m_mem[a] = {r64(), r64(), r64(), r64()};
      store_valid_mem = 1; drive_mem(7'(a), m_mem[a]);
      tick();
    end
    store_valid_mem = 0;
    m_cnt = 128;
    // Drain the fill, so the model count starts from zero afterwards
    run_drain(0, 100, 0, 0, 10'd1, -1);

    // Same-address write and read at the top address
    curr_cycle(1, 7'h7F, 1, 7'h7F, 0);
    // Random curr traffic with bypass hits and stalls
    for (int c = 0; c < 300; c++) begin
      logic [6:0] wa, ra;
      wa = 7'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? wa : 7'($urandom);
      curr_cycle($urandom_range(0, 1), wa, $urandom_range(0, 1), ra,
                 ($urandom_range(0, 3) == 0));
    end

    // Three-beat drain, always ready, read_num 5
    run_drain(3, 100, 0, 0, 10'd5, -1);
    // Same drain with partial readiness
    run_drain(3, 50, 0, 0, 10'd5, -1);
    // Full-depth drain
    run_drain(128, 80, 0, 0, 10'($urandom), -1);
    // Same-cycle mem write with last_one_read becomes beat 0
    run_drain(0, 70, 1, 0, 10'd9, -1);
    // Random sizes, some with dropped writes during the drain
    for (int t = 0; t < 6; t++)
      run_drain($urandom_range(1, 20), $urandom_range(30, 100), $urandom_range(0, 1),
                $urandom_range(0, 1), 10'($urandom), -1);
    run_drain(4, 60, 0, 1, 10'd3, -1);

    // Reset mid-drain after 3 of 5 beats
    run_drain(5, 100, 0, 0, 10'd7, 3);
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    m_cnt = 0; m_ovf = 0; m_rd = '0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ovf", 64'(overflow_err), 64'd0);
    check("midrst_rd", rd_x_0, 64'd0);
    run_drain(0, 100, 0, 0, 10'd2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
